// File: rtl/logic_unit_arb_pkg.sv
// Shared types for the logic-unit arbiter: opcode and response-stage state encodings.
package logic_arb_pkg;

  typedef enum logic [1:0] {OPC_AND, OPC_OR, OPC_XOR, OPC_NAND} t_opc;
  typedef enum logic {S_IDLE, S_FULL} t_arb_state;

  localparam int OPC_W = 2;

endpackage

// File: rtl/logic_unit_arb_if.sv
// Request/response bundle between the requesters, the consumer and logic_unit_arb.
interface logic_unit_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_opa;
  logic [NUM_REQ*WIDTH-1:0] req_opb;
  logic [NUM_REQ*2-1:0]     req_opc;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;

  modport master (
    output req_valid, req_opa, req_opb, req_opc, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_opa, req_opb, req_opc, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/logic_unit_arb_rr_pick.sv
// Combinational requester picker: round-robin from ptr, or lowest-index-wins
// when LOGIC_ARB_FIXED_PRIO_EN is defined (ptr port then disappears).
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
`ifndef LOGIC_ARB_FIXED_PRIO_EN
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int ID_W = $clog2(NUM_REQ);

  assign any = |req;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest valid index is the last (winning) write.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = ID_W'(k);
      end
    end
  end
`else
  always_comb begin
    logic found;
    int   pos;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = ID_W'(pos);
      end
    end
  end
`endif

endmodule

// File: rtl/logic_unit_arb.sv
// Shares one AND/OR/XOR/NAND unit between NUM_REQ requesters behind a single-entry
// response register. Define LOGIC_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module logic_unit_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  logic_unit_arb_if.slave bus
);
  import logic_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [0:0] ST_IDLE = S_IDLE;
  localparam logic [0:0] ST_FULL = S_FULL;

  logic [0:0]       state_reg, state_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [ID_W-1:0]  rsp_id_reg, rsp_id_next;

  logic [NUM_REQ-1:0]            pick_grant;
  logic [ID_W-1:0]               pick_idx;
  logic                          pick_any;
  logic                          can_accept;
  logic                          xfer;
  logic [NUM_REQ-1:0][WIDTH-1:0] op_result;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] ptr_reg, ptr_next;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    .ptr   (ptr_reg),
`endif
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A pop in the same cycle frees the stage, so a new grant needs no bubble.
  assign can_accept    = (state_reg == ST_IDLE) | (bus.rsp_ready & (state_reg == ST_FULL));
  assign xfer          = rst_n & can_accept & pick_any;
  assign bus.req_ready = xfer ? pick_grant : '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op
      logic [WIDTH-1:0] a_g, b_g;
      logic [1:0]       opc_g;
      assign a_g   = bus.req_opa[gi*WIDTH +: WIDTH];
      assign b_g   = bus.req_opb[gi*WIDTH +: WIDTH];
      assign opc_g = bus.req_opc[gi*2 +: 2];
      assign op_result[gi] = (opc_g == OPC_AND) ? (a_g & b_g) :
                             (opc_g == OPC_OR)  ? (a_g | b_g) :
                             (opc_g == OPC_XOR) ? (a_g ^ b_g) :
                                                  ~(a_g & b_g);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_id_next    = rsp_id_reg;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    ptr_next       = ptr_reg;
`endif
    if (xfer) begin
      state_next     = ST_FULL;
      rsp_valid_next = 1'b1;
      rsp_data_next  = op_result[pick_idx];
      rsp_id_next    = pick_idx;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      ptr_next       = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
`endif
    end else if ((state_reg == ST_FULL) && bus.rsp_ready) begin
      // Data and ID intentionally hold their last values after the pop.
      state_next     = ST_IDLE;
      rsp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      ptr_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_id_reg    <= rsp_id_next;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      ptr_reg       <= ptr_next;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;

endmodule
